ssk_rd_stream: RTL and testbench
================================

Name: ssk_rd_stream

Overview:
- Reads session key material out of the session key memory over its word read port (cmd_op / rd_addr / rd_d).
- Serializes each selected region into a byte stream with a valid/ready handshake, for the SPI response path.
- One region per start command, selected by a 3-bit region code equal to the memory's cmd_op encoding.
- Aborts immediately when the session keys are cleared or expire.

Parameters:
- MSB_FIRST, 1, byte order within each 32-bit word. 1 sends [31:24] first; 0 sends [7:0] first.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to stream a region; sampled only in IDLE
- region  input  3  region code, sampled with start: 6=cw mac (12 words), 7=sw mac (12), 4=cw blk (8), 5=sw blk (8), 2=cw iv (4), 3=sw iv (4)
- clr_ssk  input  1  key clear; aborts the stream
- ss_expire  input  1  session expiry; aborts the stream
- cmd_op  output  3  memory read region code
- rd_addr  output  4  memory read word index
- rd_d  input  32  memory read data, combinational from cmd_op/rd_addr
- out_data  output  8  stream byte
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts the byte when out_valid&out_ready
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last byte is accepted
- err  output  1  one-cycle pulse when start carries an invalid region code
- aborted  output  1  one-cycle pulse when a stream is killed by clr_ssk/ss_expire

Behaviour:
- Reset: all outputs 0; state IDLE; internal shift register, word and byte counters 0.
- All outputs are registered, except that out_data is driven directly from the shift register.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - start with a valid region: latch region into cmd_op, set rd_addr=0 and last=N-1 (N=12/8/4), go to LOAD.
  - start with region 0 or 1: err=1 for one cycle, stay in IDLE, no read issued.
- LOAD (one cycle):
  - cmd_op/rd_addr are stable from register outputs. Capture rd_d into the 32-bit shift register at the clock edge.
  - Byte count=0. Go to SEND.
- SEND:
  - out_valid=1.
  - out_data = shreg[31:24] when MSB_FIRST=1, else shreg[7:0].
  - out_data is stable while out_valid=1 and out_ready=0.
  - On handshake: shift by 8 bits toward the output end and increment the byte count.
  - On the 4th handshake, drop out_valid in the next cycle, then:
    - rd_addr != last: increment rd_addr (4-bit, no wrap reachable since last ≤ 11) and go to LOAD.
    - rd_addr == last: go to DONE.
- DONE (one cycle): done=1; cmd_op and rd_addr return to 0; go to IDLE.
- Timing:
  - Latency from start to first out_valid: 2 cycles.
  - Full-rate throughput with out_ready tied high: 5 cycles per word.
  - Total for N words: 5N+1 cycles from start to done.
- Abort (clr_ssk|ss_expire in any non-IDLE state), in the next cycle:
  - State is IDLE; out_valid=0; cmd_op=0, rd_addr=0.
  - aborted=1 for one cycle; no done pulse.
  - If abort occurs in the same cycle as the final handshake, abort wins: aborted=1, done=0.
- Abort while IDLE: no effect. start in the same cycle as clr_ssk/ss_expire: start is ignored and no pulse is issued.
- start while busy: ignored, no err.
- Asynchronous reset mid-stream: everything returns to reset values immediately; no pulses.
- The block never writes memory. Contents zeroed by the memory during a stream are never observed, because the same clear aborts the stream.

Test Plan:
- Stream region 2, memory words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, out_ready=1, MSB_FIRST=1 -> 16 bytes 00 11 22 … FF in order; rd_addr steps 0..3; done 21 cycles after start; busy low the following cycle.
- Region 6, 12 words, out_ready toggling 1-0 each cycle -> 48 bytes in order; out_data held constant across every stall; cmd_op=6 throughout; exactly one done pulse.
- start with region=1 -> err pulse for one cycle, busy stays 0, cmd_op/rd_addr stay 0; repeat with region=0 -> same.
- Region 4 stream, assert ss_expire after the 10th byte handshake -> next cycle out_valid=0, aborted=1, busy=0, no done pulse; a following start with region 5 streams correctly.
- MSB_FIRST=0, region 3, word0=0xA1B2C3D4 -> first four bytes D4 C3 B2 A1.
- Pulse rst_n low during SEND of region 7 -> outputs 0 asynchronously; a second start while busy in a new stream is ignored and byte count stays unaffected.

Source files
------------

// File: rtl/ssk_rd_stream.sv
// Purpose: read a session key region word-by-word and serialize it into a byte stream.
// Ports: start/region request a region; cmd_op/rd_addr/rd_d form the memory read port;
//        out_data/out_valid/out_ready carry the stream; busy/done/err/aborted report status.
// Latency: 2 cycles start->first byte, 5 cycles per word, done 5N+1 cycles after start.
// Backpressure: out_data holds while out_valid & !out_ready; clr_ssk/ss_expire abort at once.
module ssk_rd_stream #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  region,
  input  logic        clr_ssk,
  input  logic        ss_expire,
  output logic [2:0]  cmd_op,
  output logic [3:0]  rd_addr,
  input  logic [31:0] rd_d,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aborted
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] shreg, shreg_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [3:0]  last, last_nxt;
  logic [2:0]  cmd_op_nxt;
  logic [3:0]  rd_addr_nxt;
  logic        out_valid_nxt, busy_nxt, done_nxt, err_nxt, aborted_nxt;

  logic       abort;
  logic       hs;
  logic       region_ok;
  logic [3:0] region_last;
  logic       word_end;

  assign abort     = clr_ssk | ss_expire;
  assign hs        = out_valid & out_ready;
  assign word_end  = hs && (byte_cnt == 2'd3);
  // Codes 0 and 1 have no key region behind them.
  assign region_ok = (region[2:1] != 2'b00);

  always_comb begin
    case (region[2:1])
      2'b11:   region_last = 4'd11;
      2'b10:   region_last = 4'd7;
      2'b01:   region_last = 4'd3;
      default: region_last = 4'd0;
    endcase
  end

  assign out_data = MSB_FIRST ? shreg[31:24] : shreg[7:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !abort && region_ok) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: if (word_end) state_nxt = (rd_addr == last) ? DONE : LOAD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A clear or expiry kills the stream regardless of where it is.
    if (state != IDLE && abort) state_nxt = IDLE;
  end

  // Output / datapath next values; registered below so every status output is a flop.
  always_comb begin
    cmd_op_nxt    = cmd_op;
    rd_addr_nxt   = rd_addr;
    last_nxt      = last;
    shreg_nxt     = shreg;
    byte_cnt_nxt  = byte_cnt;
    err_nxt       = 1'b0;
    aborted_nxt   = 1'b0;
    out_valid_nxt = (state_nxt == SEND);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (region_ok) begin
            cmd_op_nxt  = region;
            rd_addr_nxt = 4'd0;
            last_nxt    = region_last;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        shreg_nxt    = rd_d;
        byte_cnt_nxt = 2'd0;
      end
      SEND: begin
        if (hs) begin
          shreg_nxt    = MSB_FIRST ? {shreg[23:0], 8'h00} : {8'h00, shreg[31:8]};
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (word_end && rd_addr != last) rd_addr_nxt = rd_addr + 4'd1;
        end
      end
      DONE: begin
        cmd_op_nxt  = 3'd0;
        rd_addr_nxt = 4'd0;
      end
      default: ;
    endcase
    if (state != IDLE && abort) begin
      aborted_nxt  = 1'b1;
      cmd_op_nxt   = 3'd0;
      rd_addr_nxt  = 4'd0;
      byte_cnt_nxt = 2'd0;
      // Do not leave key bytes sitting in the shift register after a kill.
      shreg_nxt    = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_op    <= 3'd0;
      rd_addr   <= 4'd0;
      last      <= 4'd0;
      shreg     <= 32'd0;
      byte_cnt  <= 2'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      cmd_op    <= cmd_op_nxt;
      rd_addr   <= rd_addr_nxt;
      last      <= last_nxt;
      shreg     <= shreg_nxt;
      byte_cnt  <= byte_cnt_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      aborted   <= aborted_nxt;
    end
  end

endmodule

// File: tb/tb_ssk_rd_stream.sv
module tb_ssk_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_b = 1'b0;
  logic [2:0]  region = 3'd0;
  logic        clr_ssk = 1'b0, ss_expire = 1'b0;
  logic        out_ready = 1'b1;

  logic [2:0]  cmd_op, cmd_op_b;
  logic [3:0]  rd_addr, rd_addr_b;
  logic [31:0] rd_d, rd_d_b;
  logic [7:0]  out_data, out_data_b;
  logic        out_valid, out_valid_b;
  logic        busy, busy_b, done, done_b, err, err_b, aborted, aborted_b;

  logic [31:0] mem [8][16];
  assign rd_d   = mem[cmd_op][rd_addr];
  assign rd_d_b = mem[cmd_op_b][rd_addr_b];

  ssk_rd_stream #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .region(region),
    .clr_ssk(clr_ssk), .ss_expire(ss_expire), .cmd_op(cmd_op), .rd_addr(rd_addr),
    .rd_d(rd_d), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .aborted(aborted)
  );

  ssk_rd_stream #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start_b), .region(region),
    .clr_ssk(clr_ssk), .ss_expire(ss_expire), .cmd_op(cmd_op_b), .rd_addr(rd_addr_b),
    .rd_d(rd_d_b), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b), .done(done_b), .err(err_b), .aborted(aborted_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: stimulus pushes expected bytes, monitors pop on each handshake.
  logic [7:0] exp_q[$];
  logic [7:0] exp_b[$];
  int  hs_cnt = 0;
  int  done_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held = 8'h00;

  always @(negedge clk) begin
    if (stall_prev && out_valid) chk("stall_hold", out_data, held);
    stall_prev = out_valid && !out_ready;
    held       = out_data;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("unexpected_byte", out_data, 32'hFFFF_FFFF);
      else chk("byte", out_data, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (out_valid_b && out_ready) begin
      if (exp_b.size() == 0) chk("unexpected_byte_lsb", out_data_b, 32'hFFFF_FFFF);
      else chk("byte_lsb", out_data_b, exp_b.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input bit side_b, input logic [31:0] w, input bit msb);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = msb ? w[31-8*i -: 8] : w[8*i +: 8];
      if (side_b) exp_b.push_back(b);
      else        exp_q.push_back(b);
    end
  endtask

  task automatic push_region(input bit side_b, input int r, input int n, input bit msb);
    for (int a = 0; a < n; a++) push_word(side_b, mem[r][a], msb);
  endtask

  // Issue start on the main DUT; leaves the bench in cycle 1 (LOAD).
  task automatic kick(input logic [2:0] r);
    region = r;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    int k, base, dbase;
    for (int r = 0; r < 8; r++)
      for (int a = 0; a < 16; a++)
        mem[r][a] = {4'(r), 4'(a), 8'h5A, 4'(a), 4'(r), 8'hC3};
    mem[2][0] = 32'h0011_2233; mem[2][1] = 32'h4455_6677;
    mem[2][2] = 32'h8899_AABB; mem[2][3] = 32'hCCDD_EEFF;
    mem[3][0] = 32'hA1B2_C3D4;

    // Reset state
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_op", cmd_op, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pulses", {done, err, aborted}, 0);
    rst_n = 1'b1;
    step();

    // Region 2, full rate: timing and address stepping
    push_region(0, 2, 4, 1);
    dbase = done_cnt;
    kick(3'd2);
    k = 1;
    chk("t1_load_busy", busy, 1);
    chk("t1_load_cmd_op", cmd_op, 2);
    chk("t1_load_valid", out_valid, 0);
    while (!done && k < 40) begin
      step(); k++;
      if (k == 2) chk("t1_first_valid", out_valid, 1);
      if (k < 21 && (k % 5) == 2) chk("t1_rd_addr", rd_addr, 32'((k - 2) / 5));
    end
    chk("t1_done_cycle", k, 21);
    step();
    chk("t1_busy_after", busy, 0);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_done_count", done_cnt - dbase, 1);

    // Region 6, out_ready toggling
    push_region(0, 6, 12, 1);
    dbase = done_cnt;
    kick(3'd6);
    k = 1;
    while (!done && k < 400) begin
      if (busy) chk("t2_cmd_op", cmd_op, 6);
      out_ready = ~out_ready;
      step(); k++;
    end
    chk("t2_timeout", k < 400, 1);
    out_ready = 1'b1;
    step(); step();
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_done_count", done_cnt - dbase, 1);

    // Invalid region codes
    for (int r = 1; r >= 0; r--) begin
      region = 3'(r); start = 1'b1;
      step();
      start = 1'b0;
      chk("t3_err", err, 1);
      chk("t3_busy", busy, 0);
      chk("t3_cmd_op", cmd_op, 0);
      chk("t3_rd_addr", rd_addr, 0);
      step();
      chk("t3_err_clear", err, 0);
    end

    // start together with clr_ssk in IDLE is ignored
    clr_ssk = 1'b1;
    kick(3'd6);
    clr_ssk = 1'b0;
    chk("t3b_busy", busy, 0);
    chk("t3b_pulses", {done, err, aborted}, 0);

    // Region 4, ss_expire after 10th byte
    for (int a = 0; a < 2; a++) push_word(0, mem[4][a], 1);
    exp_q.push_back(mem[4][2][31:24]);
    exp_q.push_back(mem[4][2][23:16]);
    base = hs_cnt; dbase = done_cnt;
    kick(3'd4);
    k = 1;
    while (hs_cnt - base < 10 && k < 100) begin step(); k++; end
    chk("t4_timeout", k < 100, 1);
    out_ready = 1'b0; ss_expire = 1'b1;
    step();
    ss_expire = 1'b0; out_ready = 1'b1;
    chk("t4_valid", out_valid, 0);
    chk("t4_aborted", aborted, 1);
    chk("t4_busy", busy, 0);
    chk("t4_cmd_op", cmd_op, 0);
    step();
    chk("t4_aborted_clear", aborted, 0);
    chk("t4_no_done", done_cnt - dbase, 0);
    chk("t4_queue_empty", exp_q.size(), 0);

    // Region 5 after the abort
    push_region(0, 5, 8, 1);
    dbase = done_cnt;
    kick(3'd5);
    k = 1;
    while (!done && k < 100) begin step(); k++; end
    chk("t4b_done_cycle", k, 41);
    step();
    chk("t4b_queue_empty", exp_q.size(), 0);
    chk("t4b_done_count", done_cnt - dbase, 1);

    // Abort on the final handshake: abort wins
    push_region(0, 2, 4, 1);
    base = hs_cnt; dbase = done_cnt;
    kick(3'd2);
    k = 1;
    while (hs_cnt - base < 15 && k < 100) begin step(); k++; end
    clr_ssk = 1'b1;
    step();
    clr_ssk = 1'b0;
    chk("t5_aborted", aborted, 1);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    step();
    chk("t5_no_done", done_cnt - dbase, 0);
    chk("t5_queue_empty", exp_q.size(), 0);

    // LSB-first instance, region 3
    push_region(1, 3, 4, 0);
    chk("t6_first_byte_model", exp_b[0], 8'hD4);
    region = 3'd3; start_b = 1'b1;
    step();
    start_b = 1'b0;
    k = 1;
    while (!done_b && k < 60) begin step(); k++; end
    chk("t6_done_cycle", k, 21);
    step();
    chk("t6_queue_empty", exp_b.size(), 0);

    // Async reset in SEND of region 7
    push_region(0, 7, 12, 1);
    base = hs_cnt;
    kick(3'd7);
    k = 1;
    while (hs_cnt - base < 6 && k < 100) begin step(); k++; end
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_cmd_op", cmd_op, 0);
    chk("t7_rst_rd_addr", rd_addr, 0);
    chk("t7_rst_out_data", out_data, 0);
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();

    // Fresh stream with a second start while busy
    push_region(0, 7, 12, 1);
    base = hs_cnt; dbase = done_cnt;
    kick(3'd7);
    k = 1;
    step(); step(); k += 2;
    region = 3'd2; start = 1'b1;
    step(); k++;
    start = 1'b0;
    chk("t7_busy_start_err", err, 0);
    chk("t7_busy_start_cmd", cmd_op, 7);
    while (!done && k < 200) begin step(); k++; end
    chk("t7_done_cycle", k, 61);
    step();
    chk("t7_bytes", hs_cnt - base, 48);
    chk("t7_queue_empty", exp_q.size(), 0);
    chk("t7_done_count", done_cnt - dbase, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
